// File: rtl/sc_spi_target.sv
// SPI target engine, fully oversampled on SYSCLK: all four CPOL/CPHA modes, 1..32 bit words,
// MSB/LSB first, valid/ack word handshake. Define SC_SPI_TARGET_SYNC_EN to add 2-flop input synchronizers.
module sc_spi_target (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  input  logic [5:0]  DWIDTH,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic [31:0] TXDATA,
  input  logic        TXVALID,
  output logic        TXACK,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic        UNDERRUN,
  output logic        SPIBUSY,
  output logic        SPICOMPLETE,
  input  logic        CSB,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic logic [5:0] eff_width(input logic [5:0] w);
    return (w == 6'd0 || w > 6'd32) ? 6'd32 : w;
  endfunction

  function automatic logic [31:0] width_mask(input logic [5:0] w);
    return 32'hFFFF_FFFF >> (6'd32 - w);
  endfunction

  logic csb_s, sclk_s, mosi_s;

  // CSB is reset to the asserted level so that a pin already low when reset is released
  // does not look like a fresh fall; a transaction needs a genuine high-to-low transition.
`ifdef SC_SPI_TARGET_SYNC_EN
  logic [1:0] csb_q, sclk_q, mosi_q;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      csb_q  <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      csb_q  <= {csb_q[0], CSB};
      sclk_q <= {sclk_q[0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign csb_s  = csb_q[1];
  assign sclk_s = sclk_q[1];
  assign mosi_s = mosi_q[1];
`else
  logic csb_q, sclk_q, mosi_q;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      csb_q  <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      csb_q  <= CSB;
      sclk_q <= SCLK;
      mosi_q <= MOSI;
    end
  end

  assign csb_s  = csb_q;
  assign sclk_s = sclk_q;
  assign mosi_s = mosi_q;
`endif

  logic [0:0]  state;
  logic        csb_d, sclk_d;
  logic [5:0]  dw_l;
  logic        cpol_l, cpha_l, border_l;
  logic [5:0]  bit_cnt;
  logic [31:0] rx_sh, tx_sh;
  logic        reload_armed, first_shift;

  logic        active, csb_fall, csb_rise, lead, trail;
  logic        sample_edge, shift_edge, load_now;
  logic [5:0]  dw_in, dw_use, cnt_next;
  logic        border_use;
  logic [4:0]  top_use, top_l;
  logic [31:0] load_word, rx_next, rx_word, tx_adv;
  logic        load_bit, tx_adv_bit;

  assign active   = (state == ST_ACTIVE);
  assign csb_fall = csb_d & ~csb_s;
  assign csb_rise = ~csb_d & csb_s;
  assign lead     = (sclk_d == cpol_l) && (sclk_s != cpol_l);
  assign trail    = (sclk_d != cpol_l) && (sclk_s == cpol_l);

  // A CSB rise in the same cycle as an SCLK edge ends the transaction and the edge is dropped.
  assign sample_edge = active & ~csb_rise & (cpha_l ? trail : lead);
  assign shift_edge  = active & ~csb_rise & (cpha_l ? lead : trail);
  assign load_now    = (~active & csb_fall) | (shift_edge & reload_armed);

  assign TXACK    = load_now & TXVALID;
  assign UNDERRUN = load_now & ~TXVALID;
  assign SPIBUSY  = active;

  // The CSB-fall load uses the live config, later reloads the per-transaction copy.
  assign dw_in      = eff_width(DWIDTH);
  assign dw_use     = active ? dw_l : dw_in;
  assign border_use = active ? border_l : BORDER;
  assign top_use    = 5'(dw_use - 6'd1);
  assign top_l      = 5'(dw_l - 6'd1);
  assign load_word  = TXVALID ? (TXDATA & width_mask(dw_use)) : 32'd0;
  assign load_bit   = border_use ? load_word[0] : load_word[top_use];

  // LSB-first words fill from bit 31 down, so the finished word is right-justified by shifting.
  assign rx_next  = border_l ? {mosi_s, rx_sh[31:1]} : {rx_sh[30:0], mosi_s};
  assign rx_word  = border_l ? (rx_next >> (6'd32 - dw_l)) : (rx_next & width_mask(dw_l));
  assign cnt_next = bit_cnt + 6'd1;

  assign tx_adv     = border_l ? (tx_sh >> 1) : (tx_sh << 1);
  assign tx_adv_bit = border_l ? tx_adv[0] : tx_adv[top_l];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state        <= ST_IDLE;
      csb_d        <= 1'b0;
      sclk_d       <= 1'b0;
      dw_l         <= 6'd32;
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      border_l     <= 1'b0;
      bit_cnt      <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      reload_armed <= 1'b0;
      first_shift  <= 1'b0;
      RXDATA       <= '0;
      RXVALID      <= 1'b0;
      SPICOMPLETE  <= 1'b0;
      MISO         <= 1'b0;
      MISO_OE      <= 1'b0;
    end else begin
      csb_d       <= csb_s;
      sclk_d      <= sclk_s;
      RXVALID     <= 1'b0;
      SPICOMPLETE <= 1'b0;

      if (!active) begin
        if (csb_fall) begin
          state        <= ST_ACTIVE;
          dw_l         <= dw_in;
          cpol_l       <= CPOL;
          cpha_l       <= CPHA;
          border_l     <= BORDER;
          bit_cnt      <= '0;
          reload_armed <= 1'b0;
          first_shift  <= CPHA;
          tx_sh        <= load_word;
          MISO         <= load_bit;
          MISO_OE      <= 1'b1;
        end
      end else if (csb_rise) begin
        state        <= ST_IDLE;
        MISO_OE      <= 1'b0;
        SPICOMPLETE  <= 1'b1;
        reload_armed <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_sh <= rx_next;
          if (cnt_next == dw_l) begin
            RXDATA       <= rx_word;
            RXVALID      <= 1'b1;
            bit_cnt      <= '0;
            reload_armed <= 1'b1;
          end else begin
            bit_cnt <= cnt_next;
          end
        end

        // With CPHA=1 the first leading edge presents bit 0 of the word loaded at CSB fall.
        if (shift_edge) begin
          if (reload_armed) begin
            tx_sh        <= load_word;
            MISO         <= load_bit;
            reload_armed <= 1'b0;
          end else if (first_shift) begin
            first_shift <= 1'b0;
          end else begin
            tx_sh <= tx_adv;
            MISO  <= tx_adv_bit;
          end
        end
      end
    end
  end

endmodule
